// File: rtl/wallace_reduce_pipe_if.sv
// rtl/wallace_reduce_pipe_if.sv - handshake bundle between pp stage, Wallace reducer and consumer
//
// Purpose: groups the input (partial-product) and output (product) valid/ready
// channels of wallace_reduce_pipe into one interface.
//
// Signals:
//   in_valid   pp bus holds a valid row set            (master -> slave)
//   in_ready   reducer accepts pp this cycle            (slave  -> master)
//   pp         33 packed 64-bit rows, row i = pp[i]     (master -> slave)
//   out_valid  product valid                            (slave  -> master)
//   out_ready  downstream accepts product               (master -> slave)
//   product    sum of all rows modulo 2^64              (slave  -> master)
//   acc_clr    accumulator clear, only with WALLACE_MAC_EN (master -> slave)
//
// Modports: master = surrounding logic / bench, slave = wallace_reduce_pipe.
// Optional feature macro: WALLACE_MAC_EN adds acc_clr.

interface wallace_reduce_pipe_if;
  logic                 in_valid;
  logic                 in_ready;
  logic [32:0][63:0]    pp;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          product;
`ifdef WALLACE_MAC_EN
  logic                 acc_clr;

  modport master (
    output in_valid, pp, out_ready, acc_clr,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, pp, out_ready, acc_clr,
    output in_ready, out_valid, product
  );
`else
  modport master (
    output in_valid, pp, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, pp, out_ready,
    output in_ready, out_valid, product
  );
`endif
endinterface

// File: rtl/wallace_reduce_pipe.sv
// rtl/wallace_reduce_pipe.sv - pipelined 33-row Wallace reducer with final carry-propagate adder
//
// Purpose: compresses the 33 x 64-bit partial-product rows of the 32x32 signed
// multiplier to two rows through 8 fixed 3:2 carry-save levels
// (33->22->15->10->7->5->4->3->2), then adds them into a registered 64-bit
// product. Sign handling is already folded into the rows upstream; this block
// is a plain modulo-2^64 adder of all rows.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     wallace_reduce_pipe_if.slave: in_valid/in_ready/pp on the input
//           side, out_valid/out_ready/product on the output side
//
// Parameters:
//   REG_EVERY  CSA levels between pipeline register banks (1, 2, 4 or 8).
//              Latency from input handshake to out_valid = 8/REG_EVERY + 1.
//
// Optional feature macro: WALLACE_MAC_EN
//   Adds bus.acc_clr and a 64-bit accumulator; product = tree sum + acc.

module wallace_reduce_pipe #(
  parameter int REG_EVERY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wallace_reduce_pipe_if.slave  bus
);

  localparam int NROWS = 33;
  localparam int W     = 64;
  localparam int NLVL  = 8;
  localparam int NB    = NLVL / REG_EVERY;

  // Rows entering level k; level k emits level_rows(k+1) rows.
  function automatic int level_rows(input int k);
    case (k)
      0:       level_rows = 33;
      1:       level_rows = 22;
      2:       level_rows = 15;
      3:       level_rows = 10;
      4:       level_rows = 7;
      5:       level_rows = 5;
      6:       level_rows = 4;
      7:       level_rows = 3;
      default: level_rows = 2;
    endcase
  endfunction

  // Pipeline state
  logic [W-1:0]  bank_q [NB][NROWS];
  logic [NB-1:0] vld_q;
  logic          out_valid_q;
  logic [W-1:0]  product_q;

  // Combinational tree
  logic [W-1:0]  lvl_out [NLVL][NROWS];
  logic [W-1:0]  cur [NROWS];
  logic [W-1:0]  nxt [NROWS];
  logic [W-1:0]  ca, cb, cc;
  int            nr, ng;

  logic          stall;
  logic [W-1:0]  cpa_sum;

  // A full output register that is not being taken freezes the whole pipe.
  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  // Eight CSA levels. Level k reads the pp bus (k == 0), a register bank
  // (k is a multiple of REG_EVERY) or the previous level directly.
  // Rows that do not fill a group of three are carried through unchanged,
  // placed right after the sum/carry pairs.
  always_comb begin
    for (int k = 0; k < NLVL; k++) begin
      for (int i = 0; i < NROWS; i++) begin
        lvl_out[k][i] = '0;
      end
    end
    for (int i = 0; i < NROWS; i++) begin
      cur[i] = '0;
      nxt[i] = '0;
    end
    ca = '0;
    cb = '0;
    cc = '0;
    nr = 0;
    ng = 0;

    for (int k = 0; k < NLVL; k++) begin
      for (int i = 0; i < NROWS; i++) begin
        if (k == 0) begin
          cur[i] = bus.pp[i];
        end else if ((k % REG_EVERY) == 0) begin
          cur[i] = bank_q[(k / REG_EVERY) - 1][i];
        end else begin
          cur[i] = lvl_out[k - 1][i];
        end
      end

      nr = level_rows(k);
      ng = nr / 3;

      for (int i = 0; i < NROWS; i++) begin
        nxt[i] = '0;
      end

      for (int g = 0; g < NROWS / 3; g++) begin
        if (g < ng) begin
          ca = cur[3*g];
          cb = cur[3*g + 1];
          cc = cur[3*g + 2];
          nxt[2*g]     = ca ^ cb ^ cc;
          // Carry weight is one bit up; the bit shifted past bit 63 is dropped.
          nxt[2*g + 1] = ((ca & cb) | (ca & cc) | (cb & cc)) << 1;
        end
      end

      // Leftover row i lands at 2*ng + (i - 3*ng) = i - ng.
      for (int i = 0; i < NROWS; i++) begin
        if ((i >= 3*ng) && (i < nr)) begin
          nxt[i - ng] = cur[i];
        end
      end

      for (int i = 0; i < NROWS; i++) begin
        lvl_out[k][i] = nxt[i];
      end
    end
  end

`ifdef WALLACE_MAC_EN
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_nxt;
  logic         out_hs;
  logic [W-1:0] mac_s;
  logic [W-1:0] mac_c;

  // The accumulator value the CPA sees is the one that will hold after this
  // edge, so a result entering the output register on the same edge that the
  // previous result is handed off already includes that previous result.
  always_comb begin
    out_hs = out_valid_q & bus.out_ready;
    if (bus.acc_clr) begin
      acc_nxt = '0;
    end else if (out_hs) begin
      acc_nxt = product_q;
    end else begin
      acc_nxt = acc_q;
    end
    mac_s   = bank_q[NB-1][0] ^ bank_q[NB-1][1] ^ acc_nxt;
    mac_c   = ((bank_q[NB-1][0] & bank_q[NB-1][1]) |
               (bank_q[NB-1][0] & acc_nxt) |
               (bank_q[NB-1][1] & acc_nxt)) << 1;
    cpa_sum = mac_s + mac_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_nxt;
    end
  end
`else
  always_comb begin
    cpa_sum = bank_q[NB-1][0] + bank_q[NB-1][1];
  end
`endif

  // Register banks, valid chain and output register all advance together
  // and all freeze together on stall; bubbles travel with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < NROWS; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else if (!stall) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < NROWS; i++) begin
          bank_q[b][i] <= lvl_out[(b + 1) * REG_EVERY - 1][i];
        end
      end
      vld_q[0] <= bus.in_valid;
      for (int b = 1; b < NB; b++) begin
        vld_q[b] <= vld_q[b - 1];
      end
      out_valid_q <= vld_q[NB-1];
      // Keep product at zero whenever it is not carrying a result.
      product_q   <= vld_q[NB-1] ? cpa_sum : '0;
    end
  end

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// tb/tb_wallace_reduce_pipe.sv - randomized self-checking bench for wallace_reduce_pipe

module tb_wallace_reduce_pipe;

  localparam int L = 5;

  typedef logic [32:0][63:0] rows_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wallace_reduce_pipe_if bus ();

  wallace_reduce_pipe #(.REG_EVERY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a fixed-latency delay line of L slots that advances as a whole
  // unless the last slot holds a result the consumer refuses.
  logic        mv [L];
  logic [63:0] md [L];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] row_sum(input rows_t r);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 33; i++) s = s + r[i];
    return s;
  endfunction

  // Shift-and-add rows of a signed 32x32 product (top row negated).
  function automatic rows_t mul_rows(input logic [31:0] x, input logic [31:0] y);
    rows_t       r;
    logic [63:0] xs;
    r  = '0;
    xs = {{32{x[31]}}, x};
    for (int i = 0; i < 31; i++) if (y[i]) r[i] = xs << i;
    if (y[31]) r[31] = -(xs << 31);
    return r;
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] a;
    logic signed [63:0] b;
    a = {{32{x[31]}}, x};
    b = {{32{y[31]}}, y};
    return a * b;
  endfunction

  function automatic rows_t rand_rows();
    rows_t r;
    int    mode;
    r    = '0;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < 33; i++) begin
      if (mode == 0) r[i] = {$urandom, $urandom};
      else if (mode == 1) r[i] = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'd0;
      else r[i] = {64{1'b1}} >> $urandom_range(0, 63);
    end
    return r;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < L; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  // Called just after a falling edge: drive inputs, compare outputs, then
  // advance the reference for the coming rising edge.
  task automatic cycle(input logic iv, input rows_t ipp, input logic [63:0] exp,
                       input logic ordy, output logic took);
    logic stall;
    bus.in_valid  = iv;
    bus.pp        = ipp;
    bus.out_ready = ordy;
    #1;
    stall = mv[L-1] && !ordy;
    check("out_valid", 64'(bus.out_valid), 64'(mv[L-1]));
    check("product", bus.product, mv[L-1] ? md[L-1] : 64'd0);
    check("in_ready", 64'(bus.in_ready), 64'(!stall));
    took = iv && !stall && rst_n;
    if (rst_n && !stall) begin
      for (int i = L - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = iv;
      md[0] = exp;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 64'd0, 1'b1, t);
  endtask

  initial begin
    rows_t       r;
    rows_t       bpr [6];
    logic [63:0] bpe [6];
    logic [31:0] xv [8];
    logic [31:0] yv [8];
    logic [63:0] ev [8];
    logic        took;
    logic        ordy;
    logic        started;
    int          hold;
    int          idx;
    int          cnt;
    logic [63:0] cur_e;

    bus.in_valid  = 1'b0;
    bus.pp        = '0;
    bus.out_ready = 1'b1;
    model_flush();
    @(negedge clk);

    // Reset held three cycles, then idle
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 64'd0, 1'b1, took);
    rst_n = 1'b1;
    idle(3);

    // Single transaction 5 + 10
    r = '0;
    r[0] = 64'd5;
    r[1] = 64'd10;
    cycle(1'b1, r, 64'd15, 1'b1, took);
    idle(8);

    // All ones on every row
    r = '1;
    cycle(1'b1, r, 64'hFFFF_FFFF_FFFF_FFDF, 1'b1, took);
    idle(7);

    // Eight back-to-back signed products
    xv[0] = 32'hFFFF_FFF9; yv[0] = 32'd3;          ev[0] = 64'hFFFF_FFFF_FFFF_FFEB;
    xv[1] = 32'h8000_0000; yv[1] = 32'h8000_0000; ev[1] = 64'h4000_0000_0000_0000;
    xv[2] = 32'hFFFF_FFFF; yv[2] = 32'hFFFF_FFFF; ev[2] = 64'd1;
    for (int i = 3; i < 8; i++) begin
      xv[i] = $urandom;
      yv[i] = $urandom;
      ev[i] = smul(xv[i], yv[i]);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, mul_rows(xv[i], yv[i]), ev[i], 1'b1, took);
    idle(7);

    // Backpressure: 6 vectors, consumer stalls 4 cycles once output appears
    for (int i = 0; i < 6; i++) begin
      bpr[i] = rand_rows();
      bpe[i] = row_sum(bpr[i]);
    end
    idx = 0;
    started = 1'b0;
    hold = 0;
    cnt = 0;
    while ((idx < 6 || mv[0] || mv[1] || mv[2] || mv[3] || mv[4]) && cnt < 80) begin
      if (!started && mv[L-1]) begin
        started = 1'b1;
        hold = 4;
      end
      ordy = (hold == 0);
      if (hold > 0) hold--;
      cycle(idx < 6, bpr[(idx < 6) ? idx : 0], bpe[(idx < 6) ? idx : 0], ordy, took);
      if (took) idx++;
      cnt++;
    end
    idle(2);

    // Reset while three transactions are in flight
    for (int i = 0; i < 3; i++) begin
      r = rand_rows();
      cycle(1'b1, r, row_sum(r), 1'b1, took);
    end
    idle(1);
    rst_n = 1'b0;
    model_flush();
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 64'd0, 1'b1, took);
    rst_n = 1'b1;
    idle(8);
    cycle(1'b1, mul_rows(32'd12345, 32'hFFFF_0001), smul(32'd12345, 32'hFFFF_0001), 1'b1, took);
    idle(7);

    // Random traffic with random bubbles and backpressure; pp held until taken
    r = rand_rows();
    cur_e = row_sum(r);
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, r, cur_e, $urandom_range(0, 3) != 0, took);
      if (took) begin
        if ($urandom_range(0, 1) == 0) begin
          r = rand_rows();
          cur_e = row_sum(r);
        end else begin
          xv[0] = $urandom;
          yv[0] = $urandom;
          r = mul_rows(xv[0], yv[0]);
          cur_e = smul(xv[0], yv[0]);
        end
      end
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
